// File: rtl/pixel_clk_gen.sv
// Programmable integer clock divider producing a divided clock level and a one-cycle tick.
// Divide-ratio updates are staged and only take effect at a period boundary.
module pixel_clk_gen #(
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned DIV_DEFAULT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [CNT_W-1:0] div_i,
    input  logic             div_ld,
    output logic             clk_div,
    output logic             tick,
    output logic [CNT_W-1:0] div_o,
    output logic             ld_ack,
    output logic             ld_err
);

    localparam logic [CNT_W-1:0] DivRst = CNT_W'(DIV_DEFAULT);
    localparam logic [CNT_W-1:0] CntRst = CNT_W'(DIV_DEFAULT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] n_q, n_d;
    logic [CNT_W-1:0] p_q, p_d;
    logic             pv_q, pv_d;
    logic             clk_div_q, clk_div_d;
    logic             tick_q, tick_d;
    logic             ld_ack_q, ld_ack_d;
    logic             ld_err_q, ld_err_d;

    logic             wrap;
    logic [CNT_W:0]   high_len;
    logic [CNT_W:0]   cnt_inc;

    // One extra bit so that N = 2^CNT_W-1 does not overflow when rounding up.
    assign high_len = ({1'b0, n_q} + (CNT_W+1)'(1)) >> 1;
    assign cnt_inc  = {1'b0, cnt_q} + (CNT_W+1)'(1);
    assign wrap     = en && (cnt_q == (n_q - CNT_W'(1)));

    always_comb begin
        cnt_d     = cnt_q;
        n_d       = n_q;
        p_d       = p_q;
        pv_d      = pv_q;
        clk_div_d = clk_div_q;
        tick_d    = 1'b0;
        ld_ack_d  = 1'b0;
        ld_err_d  = 1'b0;

        if (wrap) begin
            cnt_d     = '0;
            tick_d    = 1'b1;
            clk_div_d = 1'b1;
            // The new ratio governs the period that starts at this wrap.
            if (pv_q) begin
                n_d      = p_q;
                pv_d     = 1'b0;
                ld_ack_d = 1'b1;
            end
        end else if (en) begin
            cnt_d     = cnt_inc[CNT_W-1:0];
            clk_div_d = (cnt_inc < high_len);
        end

        // Evaluated after the apply so a load on a wrap edge stays pending.
        if (div_ld) begin
            if (div_i != '0) begin
                p_d  = div_i;
                pv_d = 1'b1;
            end else begin
                ld_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q     <= CntRst;
            n_q       <= DivRst;
            p_q       <= '0;
            pv_q      <= 1'b0;
            clk_div_q <= 1'b0;
            tick_q    <= 1'b0;
            ld_ack_q  <= 1'b0;
            ld_err_q  <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            n_q       <= n_d;
            p_q       <= p_d;
            pv_q      <= pv_d;
            clk_div_q <= clk_div_d;
            tick_q    <= tick_d;
            ld_ack_q  <= ld_ack_d;
            ld_err_q  <= ld_err_d;
        end
    end

    assign clk_div = clk_div_q;
    assign tick    = tick_q;
    assign div_o   = n_q;
    assign ld_ack  = ld_ack_q;
    assign ld_err  = ld_err_q;

endmodule

// File: tb/tb_pixel_clk_gen.sv
// Directed vector bench for pixel_clk_gen: per-edge vector table plus a max-ratio period sequence.
module tb_pixel_clk_gen;

    localparam int unsigned CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en;
    logic [CNT_W-1:0] div_i;
    logic             div_ld;
    logic             clk_div;
    logic             tick;
    logic [CNT_W-1:0] div_o;
    logic             ld_ack;
    logic             ld_err;

    always #5 clk = ~clk;

    pixel_clk_gen #(
        .CNT_W      (CNT_W),
        .DIV_DEFAULT(4)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .div_i  (div_i),
        .div_ld (div_ld),
        .clk_div(clk_div),
        .tick   (tick),
        .div_o  (div_o),
        .ld_ack (ld_ack),
        .ld_err (ld_err)
    );

    typedef struct {
        logic             rn;
        logic             en;
        logic             ld;
        logic [CNT_W-1:0] di;
        logic             ck;
        logic             tk;
        logic [CNT_W-1:0] dv;
        logic             ak;
        logic             er;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at step %0d: got %0d, expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic v(input logic rn, input logic e, input logic ld, input int di,
                     input logic ck, input logic tk, input int dv, input logic ak,
                     input logic er);
        vec_t x;
        x.rn = rn; x.en = e; x.ld = ld; x.di = CNT_W'(di);
        x.ck = ck; x.tk = tk; x.dv = CNT_W'(dv); x.ak = ak; x.er = er;
        vecs.push_back(x);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int period;
        int high;
        int waited;
        bit seen;

        rst_n  = 1'b0;
        en     = 1'b0;
        div_ld = 1'b0;
        div_i  = '0;

        //  rn en ld  di   ck tk dv ak er
        // Reset, including a load strobe that reset must swallow
        v(0, 0, 0, 0,   0, 0, 4, 0, 0);
        v(0, 1, 1, 7,   0, 0, 4, 0, 0);
        // Default N=4: 1,1,0,0 with tick on wrap
        v(1, 1, 0, 0,   1, 1, 4, 0, 0);
        v(1, 1, 0, 0,   1, 0, 4, 0, 0);
        v(1, 1, 0, 0,   0, 0, 4, 0, 0);
        v(1, 1, 0, 0,   0, 0, 4, 0, 0);
        v(1, 1, 0, 0,   1, 1, 4, 0, 0);
        // Load 5 mid-period; old period completes
        v(1, 1, 1, 5,   1, 0, 4, 0, 0);
        v(1, 1, 0, 0,   0, 0, 4, 0, 0);
        v(1, 1, 0, 0,   0, 0, 4, 0, 0);
        v(1, 1, 0, 0,   1, 1, 5, 1, 0);
        v(1, 1, 0, 0,   1, 0, 5, 0, 0);
        v(1, 1, 0, 0,   1, 0, 5, 0, 0);
        v(1, 1, 0, 0,   0, 0, 5, 0, 0);
        v(1, 1, 0, 0,   0, 0, 5, 0, 0);
        v(1, 1, 0, 0,   1, 1, 5, 0, 0);
        // Zero load rejected
        v(1, 1, 1, 0,   1, 0, 5, 0, 1);
        v(1, 1, 0, 0,   1, 0, 5, 0, 0);
        v(1, 1, 0, 0,   0, 0, 5, 0, 0);
        v(1, 1, 0, 0,   0, 0, 5, 0, 0);
        v(1, 1, 0, 0,   1, 1, 5, 0, 0);
        // Load 6 then 3: last wins, single ack
        v(1, 1, 1, 6,   1, 0, 5, 0, 0);
        v(1, 1, 1, 3,   1, 0, 5, 0, 0);
        v(1, 1, 0, 0,   0, 0, 5, 0, 0);
        v(1, 1, 0, 0,   0, 0, 5, 0, 0);
        v(1, 1, 0, 0,   1, 1, 3, 1, 0);
        // N=3; load 6, then load 2 on the wrap that applies 6
        v(1, 1, 1, 6,   1, 0, 3, 0, 0);
        v(1, 1, 0, 0,   0, 0, 3, 0, 0);
        v(1, 1, 1, 2,   1, 1, 6, 1, 0);
        v(1, 1, 0, 0,   1, 0, 6, 0, 0);
        v(1, 1, 0, 0,   1, 0, 6, 0, 0);
        v(1, 1, 0, 0,   0, 0, 6, 0, 0);
        v(1, 1, 0, 0,   0, 0, 6, 0, 0);
        v(1, 1, 0, 0,   0, 0, 6, 0, 0);
        v(1, 1, 0, 0,   1, 1, 2, 1, 0);
        v(1, 1, 0, 0,   0, 0, 2, 0, 0);
        v(1, 1, 0, 0,   1, 1, 2, 0, 0);
        // N=1: tick and clk_div stuck high; en=0 freezes
        v(1, 1, 1, 1,   0, 0, 2, 0, 0);
        v(1, 1, 0, 0,   1, 1, 1, 1, 0);
        v(1, 1, 0, 0,   1, 1, 1, 0, 0);
        v(1, 1, 0, 0,   1, 1, 1, 0, 0);
        v(1, 0, 0, 0,   1, 0, 1, 0, 0);
        v(1, 0, 0, 0,   1, 0, 1, 0, 0);
        v(1, 0, 0, 0,   1, 0, 1, 0, 0);
        v(1, 1, 0, 0,   1, 1, 1, 0, 0);
        // Back to 4, then freeze mid-period: counter holds
        v(1, 1, 1, 4,   1, 1, 1, 0, 0);
        v(1, 1, 0, 0,   1, 1, 4, 1, 0);
        v(1, 1, 0, 0,   1, 0, 4, 0, 0);
        v(1, 0, 0, 0,   1, 0, 4, 0, 0);
        v(1, 0, 0, 0,   1, 0, 4, 0, 0);
        v(1, 1, 0, 0,   0, 0, 4, 0, 0);
        v(1, 1, 0, 0,   0, 0, 4, 0, 0);
        v(1, 1, 0, 0,   1, 1, 4, 0, 0);
        // Reset with a load pending discards it
        v(1, 1, 1, 9,   1, 0, 4, 0, 0);
        v(0, 1, 0, 0,   0, 0, 4, 0, 0);
        v(1, 0, 0, 0,   0, 0, 4, 0, 0);
        v(1, 1, 0, 0,   1, 1, 4, 0, 0);
        v(1, 1, 0, 0,   1, 0, 4, 0, 0);
        v(1, 1, 0, 0,   0, 0, 4, 0, 0);
        v(1, 1, 0, 0,   0, 0, 4, 0, 0);
        v(1, 1, 0, 0,   1, 1, 4, 0, 0);

        foreach (vecs[i]) begin
            rst_n  = vecs[i].rn;
            en     = vecs[i].en;
            div_ld = vecs[i].ld;
            div_i  = vecs[i].di;
            step();
            chk("clk_div", i, 32'(clk_div), 32'(vecs[i].ck));
            chk("tick",    i, 32'(tick),    32'(vecs[i].tk));
            chk("div_o",   i, 32'(div_o),   32'(vecs[i].dv));
            chk("ld_ack",  i, 32'(ld_ack),  32'(vecs[i].ak));
            chk("ld_err",  i, 32'(ld_err),  32'(vecs[i].er));
        end

        // Max ratio 255: period 255 with 128 high cycles
        rst_n  = 1'b0;
        en     = 1'b0;
        div_ld = 1'b0;
        step();
        rst_n  = 1'b1;
        en     = 1'b1;
        div_ld = 1'b1;
        div_i  = 8'd255;
        step();
        div_ld = 1'b0;
        seen   = 1'b0;
        waited = 0;
        while (!seen && waited < 10) begin
            step();
            waited++;
            seen = ld_ack;
        end
        chk("max_ack_seen", 0, 32'(seen), 32'd1);
        chk("max_div_o",    0, 32'(div_o), 32'd255);
        chk("max_ack_tick", 0, 32'(tick), 32'd1);
        period = 1;
        high   = clk_div ? 1 : 0;
        seen   = 1'b0;
        while (!seen && period < 300) begin
            step();
            if (tick) begin
                seen = 1'b1;
            end else begin
                period++;
                if (clk_div) high++;
            end
        end
        chk("max_next_tick", 0, 32'(seen), 32'd1);
        chk("max_period",    0, 32'(period), 32'd255);
        chk("max_high",      0, 32'(high), 32'd128);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
